// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared state encoding, defaults and bit-period derivation
// rev 1.0
// ============================================================================
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 9600;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int FIFO_CW    = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic int bit_cycles(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_4x8.sv
`default_nettype none
// ============================================================================
// sync_fifo_4x8 : 4-entry byte FIFO, accepts a push on full when popping
// rev 1.0
// ============================================================================
module sync_fifo_4x8
  import uart_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_CW-1:0]   count
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == FIFO_CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only entries covered by count are ever read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FIFO_CW'(1);
        2'b01:   count <= count - FIFO_CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// uart_tx : buffered 8-bit UART transmitter, optional parity, 1 or 2 stop bits
// rev 1.0
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BAUD       = DEF_BAUD,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_flag,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ovf
);

  localparam int BIT_CYC  = bit_cycles(CLK_FREQ, BAUD);
  localparam int STOP_N   = (STOP_BITS == 2) ? 2 : 1;
  localparam int STOP_CYC = BIT_CYC * STOP_N;
  localparam int CNT_W    = ($clog2(STOP_CYC) < 1) ? 1 : $clog2(STOP_CYC);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         idx, idx_n;
  logic [7:0]         shreg, shreg_n;
  logic               par, par_n;
  logic               tx_n;
  logic               done_n;
  logic               bit_end;
  logic               load;

  logic               pop;
  logic               push;
  logic               drop;
  logic [7:0]         fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;

  assign push    = tx_flag & (~fifo_full | pop);
  assign drop    = tx_flag & fifo_full & ~pop;
  assign tx_busy = (state != IDLE) | (fifo_count != '0);

  sync_fifo_4x8 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shreg   <= shreg_n;
      par     <= par_n;
      tx      <= tx_n;
      tx_done <= done_n;
      ovf     <= ovf | drop;
    end
  end

  // tx_n is the line level for the state being entered, so tx is a pure flop.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CNT_W'(1);
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    tx_n    = tx;
    done_n  = 1'b0;
    pop     = 1'b0;
    load    = 1'b0;
    bit_end = (state == STOP) ? (cnt == STOP_LAST) : (cnt == BIT_LAST);

    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        load  = ~fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n   = idx + 3'd1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          cnt_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
          tx_n    = 1'b1;
          load    = ~fifo_empty;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
      end
    endcase

    // Back-to-back frames start straight out of STOP with no idle cycle.
    if (load) begin
      pop     = 1'b1;
      shreg_n = fifo_dout;
      par_n   = (^fifo_dout) ^ ODD;
      state_n = START;
      cnt_n   = '0;
      tx_n    = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// tb_uart_tx : scoreboard bench for uart_tx at BIT_CYC=10
// rev 1.0
// ============================================================================
module tb_uart_tx;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_a, flag_b;
  logic [7:0] data_a, data_b;
  logic       tx_a, busy_a, done_a, ovf_a;
  logic       tx_b, busy_b, done_b, ovf_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt_a = 0;
  int   done_cnt_b = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000),
    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst(rst), .tx_flag(flag_a), .tx_data(data_a),
    .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a), .ovf(ovf_a)
  );

  uart_tx #(
    .CLK_FREQ(50_000_000), .BAUD(5_000_000),
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst(rst), .tx_flag(flag_b), .tx_data(data_b),
    .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b), .ovf(ovf_b)
  );

  always @(negedge clk) begin
    if (done_a) done_cnt_a = done_cnt_a + 1;
    if (done_b) done_cnt_b = done_cnt_b + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic line(input bit is_b);
    return is_b ? tx_b : tx_a;
  endfunction

  task automatic mwait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge clk);
      if (rst) ab = 1'b1;
    end
  endtask

  // Decodes frames mid-bit and compares each against the scoreboard head.
  task automatic mon(input bit is_b);
    string      tag;
    logic [7:0] d;
    logic       st, p, s1, s2;
    bit         ab;
    exp_t       e;
    tag = is_b ? "b" : "a";
    forever begin
      @(negedge clk);
      if (!rst && line(is_b) == 1'b0) begin
        ab = 1'b0;
        p  = 1'b0;
        s2 = 1'b1;
        mwait(5, ab);
        st = line(is_b);
        for (int i = 0; i < 8; i++) begin
          mwait(10, ab);
          d[i] = line(is_b);
        end
        if (is_b) begin
          mwait(10, ab);
          p = line(is_b);
        end
        mwait(10, ab);
        s1 = line(is_b);
        if (is_b) begin
          mwait(10, ab);
          s2 = line(is_b);
        end
        if (!ab) begin
          if ((is_b ? q_b.size() : q_a.size()) == 0) begin
            check({"mon_", tag, "_unexpected_frame"}, 32'(d), 32'hFFFF_FFFF);
          end else begin
            if (is_b) e = q_b.pop_front();
            else      e = q_a.pop_front();
            check({"mon_", tag, "_start"}, 32'(st), 32'h0);
            check({"mon_", tag, "_data"},  32'(d),  32'(e.d));
            if (is_b) check({"mon_", tag, "_parity"}, 32'(p), 32'(e.p));
            check({"mon_", tag, "_stop"}, 32'({s1, s2}), 32'h3);
          end
        end
      end
    end
  endtask

  initial mon(1'b0);
  initial mon(1'b1);

  task automatic wait_idle(input bit is_b);
    bit got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (!(is_b ? busy_b : busy_a)) got = 1'b1;
    end
    if (!got) check(is_b ? "idle_timeout_b" : "idle_timeout_a", 32'h0, 32'h1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int  pat_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int  pat_07 [12] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    int  dcount, d0, bad_line;
    bit  got;

    rst = 1'b1; flag_a = 1'b0; flag_b = 1'b0; data_a = '0; data_b = '0;
    repeat (2) @(negedge clk);
    check("rst_tx",   32'(tx_a),   32'h1);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_done", 32'(done_a), 32'h0);
    check("rst_ovf",  32'(ovf_a),  32'h0);
    check("rst_tx_b", 32'(tx_b),   32'h1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte 0xA5: latency, line pattern, tx_done timing.
    flag_a = 1'b1; data_a = 8'hA5; q_a.push_back('{8'hA5, 1'b0});
    @(negedge clk);
    flag_a = 1'b0;
    check("a5_tx_idle_after_strobe", 32'(tx_a), 32'h1);
    check("a5_busy", 32'(busy_a), 32'h1);
    @(negedge clk);
    check("a5_start_low", 32'(tx_a), 32'h0);
    got = 1'b0;
    for (int i = 1; i <= 150 && !got; i++) begin
      @(negedge clk);
      if (i % 10 == 5 && i < 100) check("a5_line_bit", 32'(tx_a), 32'(pat_a5[i / 10]));
      if (done_a) begin
        got = 1'b1;
        check("a5_done_time", 32'(i), 32'd100);
      end
    end
    if (!got) check("a5_done_timeout", 32'h0, 32'h1);
    wait_idle(1'b0);

    // Four back-to-back bytes must run as contiguous frames.
    dcount = 0;
    got = 1'b0;
    for (int j = 1; j <= 700 && !got; j++) begin
      if (j <= 4) begin
        flag_a = 1'b1; data_a = 8'(j); q_a.push_back('{8'(j), 1'b0});
      end else begin
        flag_a = 1'b0;
      end
      @(negedge clk);
      if (done_a) begin
        check("b2b_done_time", 32'(j), 32'(102 + 100 * dcount));
        dcount++;
        if (dcount == 4) got = 1'b1;
      end
    end
    flag_a = 1'b0;
    if (!got) check("b2b_done_timeout", 32'(dcount), 32'd4);
    check("b2b_ovf", 32'(ovf_a), 32'h0);
    wait_idle(1'b0);

    // Six strobes: one popped, four buffered, sixth dropped.
    d0 = done_cnt_a;
    for (int j = 0; j < 6; j++) begin
      flag_a = 1'b1; data_a = 8'(8'h11 + j);
      if (j < 5) q_a.push_back('{8'(8'h11 + j), 1'b0});
      @(negedge clk);
      if (j == 4) check("ovf_before_drop", 32'(ovf_a), 32'h0);
    end
    flag_a = 1'b0;
    check("ovf_after_drop", 32'(ovf_a), 32'h1);
    wait_idle(1'b0);
    check("ovf_frames", 32'(done_cnt_a - d0), 32'd5);
    check("ovf_sticky", 32'(ovf_a), 32'h1);
    check("ovf_sb_drained", 32'(q_a.size()), 32'h0);

    // Reset 35 clocks into a frame with two bytes queued.
    for (int j = 0; j < 3; j++) begin
      flag_a = 1'b1; data_a = 8'(8'h55 + 8'h11 * j);
      q_a.push_back('{8'(8'h55 + 8'h11 * j), 1'b0});
      @(negedge clk);
    end
    flag_a = 1'b0;
    repeat (33) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx",   32'(tx_a),   32'h1);
    check("midrst_busy", 32'(busy_a), 32'h0);
    check("midrst_done", 32'(done_a), 32'h0);
    check("midrst_ovf",  32'(ovf_a),  32'h0);
    q_a.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt_a;
    bad_line = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad_line++;
    end
    check("midrst_no_resume", 32'(bad_line), 32'h0);
    check("midrst_no_done", 32'(done_cnt_a - d0), 32'h0);

    // Strobe on the first edge after reset release must be taken.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    flag_a = 1'b1; data_a = 8'h3C; q_a.push_back('{8'h3C, 1'b0});
    @(negedge clk);
    flag_a = 1'b0;
    check("post_rst_accept", 32'(busy_a), 32'h1);
    wait_idle(1'b0);

    // Parity (even) and two stop bits: 0x07 has three ones.
    flag_b = 1'b1; data_b = 8'h07; q_b.push_back('{8'h07, 1'b1});
    @(negedge clk);
    flag_b = 1'b0;
    @(negedge clk);
    got = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clk);
      if (i % 10 == 5 && i < 120) check("p07_line_bit", 32'(tx_b), 32'(pat_07[i / 10]));
      if (done_b) begin
        got = 1'b1;
        check("p07_frame_len", 32'(i), 32'd120);
      end
    end
    if (!got) check("p07_done_timeout", 32'h0, 32'h1);
    wait_idle(1'b1);

    flag_b = 1'b1; data_b = 8'h03; q_b.push_back('{8'h03, 1'b0});
    @(negedge clk);
    flag_b = 1'b0;
    wait_idle(1'b1);

    check("sb_drained_a", 32'(q_a.size()), 32'h0);
    check("sb_drained_b", 32'(q_b.size()), 32'h0);
    check("ovf_b_clear", 32'(ovf_b), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
